// File: rtl/sreg_pkg.sv
// Shared definitions for the shift-register serial link.
//   SREG_WORD_W       bits per frame
//   SREG_SYNC_STAGES  default synchroniser depth
//   SREG_TIMEOUT_CYC  default inter-bit timeout (receiver, SREG_RX_TIMEOUT_EN builds)
//   rx_state_t        receiver FSM states
//   sreg_cnt_w()      width of a counter that must hold 0..n inclusive
package sreg_pkg;

  localparam int SREG_WORD_W      = 42;
  localparam int SREG_SYNC_STAGES = 2;
  localparam int SREG_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_t;

  function automatic int sreg_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sreg_sync.sv
// N-stage single-bit synchroniser for signals crossing into the clk domain.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (all stages clear to 0)
//   i_d    in  asynchronous input
//   o_q    out synchronised output (N clk cycles of latency)
module sreg_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/sreg_rx_deser.sv
// Serial receiver for the 42-bit shift-register link. Resynchronises
// sclk/sdata/sframe into clk, rebuilds LSB-first words and hands them out on a
// valid/ready interface. Flags short frames and output overruns.
// Optional inter-bit timeout: define SREG_RX_TIMEOUT_EN.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   sclk_in       serial clock (async), data sampled on its rising edge
//   sdata_in      serial data
//   sframe_in     frame strobe, high for the whole word
//   out_data      received word, stable while out_valid
//   out_valid     word pending, held until out_ready
//   out_ready     consumer accept
//   busy          receiving a frame
//   err_short     pulse: frame ended before WORD_W bits
//   err_overrun   pulse: word completed while previous still pending (new word dropped)
//   err_timeout   pulse: no sclk edge for TIMEOUT_CYC cycles mid-frame (0 without macro)
module sreg_rx_deser
  import sreg_pkg::*;
#(
  parameter int WORD_W      = SREG_WORD_W,
  parameter int SYNC_STAGES = SREG_SYNC_STAGES,
  parameter int TIMEOUT_CYC = SREG_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              sdata_in,
  input  logic              sframe_in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_short,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int CNT_W = sreg_cnt_w(WORD_W);

  // ---------------------------------------------------------------- input sync
  logic w_sclk_s, w_sdata_s, w_sframe_s;
  logic r_sclk_d, r_sframe_d;
  logic w_sclk_rise, w_sframe_rise, w_sframe_fall;

  sreg_sync #(.N(SYNC_STAGES)) u_sync_sclk   (.clk(clk), .rst_n(rst_n), .i_d(sclk_in),   .o_q(w_sclk_s));
  sreg_sync #(.N(SYNC_STAGES)) u_sync_sdata  (.clk(clk), .rst_n(rst_n), .i_d(sdata_in),  .o_q(w_sdata_s));
  sreg_sync #(.N(SYNC_STAGES)) u_sync_sframe (.clk(clk), .rst_n(rst_n), .i_d(sframe_in), .o_q(w_sframe_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d   <= 1'b0;
      r_sframe_d <= 1'b0;
    end else begin
      r_sclk_d   <= w_sclk_s;
      r_sframe_d <= w_sframe_s;
    end
  end

  assign w_sclk_rise   =  w_sclk_s   & ~r_sclk_d;
  assign w_sframe_rise =  w_sframe_s & ~r_sframe_d;
  assign w_sframe_fall = ~w_sframe_s &  r_sframe_d;

  // ---------------------------------------------------------------- state
  rx_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_sreg;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_err_short, r_err_ovr, r_err_to;

  logic w_clr, w_shift, w_load;
  logic w_err_short, w_err_ovr, w_err_to;
  logic w_to_hit;

  // ---------------------------------------------------------------- timeout
`ifdef SREG_RX_TIMEOUT_EN
  localparam int TO_W = sreg_cnt_w(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;

  // Counts consecutive RECV cycles without an sclk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_to_cnt <= '0;
    else if (r_state != RX_RECV || w_sclk_rise) r_to_cnt <= '0;
    else                                      r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYC-th idle cycle.
  assign w_to_hit = (r_state == RX_RECV) && !w_sclk_rise &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC > 0);  // only meaningful with the timeout built in
  assign w_to_hit     = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_err_short = 1'b0;
    w_err_ovr   = 1'b0;
    w_err_to    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_sframe_rise) begin
          w_state_nxt = RX_RECV;
          w_clr       = 1'b1;
          w_shift     = w_sclk_rise;  // edge coincident with frame start is bit 0
        end
      end
      RX_RECV: begin
        if (r_bit_cnt == CNT_W'(WORD_W)) begin
          // Full word: further sclk edges are ignored until the next frame.
          w_state_nxt = RX_DONE;
        end else if (w_to_hit) begin
          w_err_to    = 1'b1;
          w_state_nxt = RX_IDLE;
        end else if (w_sframe_fall &&
                     (r_bit_cnt + CNT_W'(w_sclk_rise)) < CNT_W'(WORD_W)) begin
          // Length check counts a bit arriving in the same cycle as the fall.
          w_err_short = 1'b1;
          w_state_nxt = RX_IDLE;
        end else begin
          w_shift = w_sclk_rise;
        end
      end
      RX_DONE: begin
        w_state_nxt = RX_IDLE;
        if (!r_out_valid || out_ready) w_load    = 1'b1;
        else                           w_err_ovr = 1'b1;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  logic [WORD_W-1:0] w_sreg_base;
  logic [CNT_W-1:0]  w_cnt_base;

  assign w_sreg_base = w_clr ? '0 : r_sreg;
  assign w_cnt_base  = w_clr ? '0 : r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (w_clr || w_shift) begin
      r_sreg    <= w_shift ? {w_sdata_s, w_sreg_base[WORD_W-1:1]} : w_sreg_base;
      r_bit_cnt <= w_cnt_base + CNT_W'(w_shift);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= r_sreg;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_short <= 1'b0;
      r_err_ovr   <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_err_short <= w_err_short;
      r_err_ovr   <= w_err_ovr;
      r_err_to    <= w_err_to;
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state == RX_RECV);
  assign err_short   = r_err_short;
  assign err_overrun = r_err_ovr;
  assign err_timeout = r_err_to;

endmodule

// File: tb/tb_sreg_rx_deser.sv
module tb_sreg_rx_deser;

  localparam int W = 42;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         sclk_in = 1'b0, sdata_in = 1'b0, sframe_in = 1'b0, out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_valid, busy, err_short, err_overrun, err_timeout;

  always #5 clk = ~clk;

  sreg_rx_deser dut (
    .clk(clk), .rst_n(rst_n),
    .sclk_in(sclk_in), .sdata_in(sdata_in), .sframe_in(sframe_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_short(err_short), .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  int n_vec = 0, n_bad = 0;

  // Monitor: accepted words and event counts, sampled mid-cycle.
  int           m_acc = 0, m_short = 0, m_ovr = 0, m_to = 0, m_vcyc = 0;
  logic [W-1:0] acc_mem [0:255];

  always @(negedge clk) begin
    if (out_valid) m_vcyc++;
    if (out_valid && out_ready) begin
      acc_mem[m_acc % 256] = out_data;
      m_acc++;
    end
    if (err_short)   m_short++;
    if (err_overrun) m_ovr++;
    if (err_timeout) m_to++;
  end

  int b_acc, b_short, b_ovr, b_to, b_vcyc;
  task automatic snap();
    b_acc = m_acc; b_short = m_short; b_ovr = m_ovr; b_to = m_to; b_vcyc = m_vcyc;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit at sclk = clk/4: data set with sclk low, rising edge 2 cycles later.
  task automatic send_bit(input logic b);
    sdata_in = b;
    sclk_in  = 1'b0; tick(2);
    sclk_in  = 1'b1; tick(2);
  endtask

  // Full frame. coinc: sframe falls together with the last sclk rise.
  // lat: measure the last-edge-to-valid latency (expects SYNC_STAGES+3 = 5).
  task automatic send_frame(input logic [W-1:0] w, input int nbits, input int extra,
                            input bit coinc, input bit lat);
    int tot;
    logic b;
    tot = nbits + extra;
    sframe_in = 1'b1; sclk_in = 1'b0; tick(2);
    for (int i = 0; i < tot; i++) begin
      if (i < W) b = w[i];
      else       b = 1'($urandom);
      sdata_in = b;
      sclk_in  = 1'b0; tick(2);
      sclk_in  = 1'b1;
      if (coinc && i == tot - 1) sframe_in = 1'b0;
      if (lat && i == W - 1) begin
        repeat (4) @(posedge clk);
        @(negedge clk); chk("latency_pre", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk); chk("latency_hit", 64'(out_valid), 64'd1);
        tick(1);
      end else begin
        tick(2);
      end
    end
    sclk_in = 1'b0; tick(2);
    sframe_in = 1'b0; tick(12);
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    int           extra;
    bit           coinc;
    int           exp_words;
    logic [W-1:0] exp_data;
    int           exp_short;
  } vec_t;

  vec_t tbl [9];

  // Expected outcome of one frame from the protocol rules: >= W bits gives the
  // first W bits LSB first as a word, anything less is a short frame.
  task automatic check_frame(input string tag, input logic [W-1:0] w, input int nbits,
                             input int ew, input logic [W-1:0] ed, input int es);
    chk({tag, "_words"}, 64'(m_acc - b_acc), 64'(ew));
    if (ew > 0) chk({tag, "_data"}, 64'(acc_mem[b_acc % 256]), 64'(ed));
    chk({tag, "_vcyc"},  64'(m_vcyc - b_vcyc), 64'(ew));
    chk({tag, "_short"}, 64'(m_short - b_short), 64'(es));
    chk({tag, "_ovr"},   64'(m_ovr - b_ovr), 64'd0);
    chk({tag, "_to"},    64'(m_to - b_to), 64'd0);
    if (nbits < 0) chk({tag, "_nb"}, 64'(w), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [W-1:0] w;
    int nb, ex, kind;

    tbl[0] = '{42'h2A5_5A5A_5A5A, 42, 0, 0, 1, 42'h2A5_5A5A_5A5A, 0};
    tbl[1] = '{42'h000_0000_0000, 42, 0, 0, 1, 42'h000_0000_0000, 0};
    tbl[2] = '{42'h3FF_FFFF_FFFF, 42, 3, 0, 1, 42'h3FF_FFFF_FFFF, 0};
    tbl[3] = '{42'h123_4567_89AB, 20, 0, 0, 0, 42'h0, 1};
    tbl[4] = '{42'h0AB_CDEF_0123, 42, 0, 0, 1, 42'h0AB_CDEF_0123, 0};
    tbl[5] = '{42'h3FF_FFFF_FFFF, 41, 0, 0, 0, 42'h0, 1};
    tbl[6] = '{42'h000_0000_0001,  1, 0, 0, 0, 42'h0, 1};
    tbl[7] = '{42'h1C3_0F0F_A5C3, 42, 0, 1, 1, 42'h1C3_0F0F_A5C3, 0};
    tbl[8] = '{42'h2AA_AAAA_AAAA, 41, 0, 1, 0, 42'h0, 1};

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_errs",  64'({err_short, err_overrun, err_timeout}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Table vectors
    for (int k = 0; k < 9; k++) begin
      snap();
      send_frame(tbl[k].word, tbl[k].nbits, tbl[k].extra, tbl[k].coinc, k == 0);
      check_frame($sformatf("vec%0d", k), tbl[k].word, tbl[k].nbits,
                  tbl[k].exp_words, tbl[k].exp_data, tbl[k].exp_short);
    end

    // Back-to-back frames with the consumer stalled
    snap();
    out_ready = 1'b0;
    send_frame(42'h1, 42, 0, 0, 0);
    send_frame(42'h3FF_FFFF_FFFF, 42, 0, 0, 0);
    chk("ovr_count", 64'(m_ovr - b_ovr), 64'd1);
    chk("ovr_valid", 64'(out_valid), 64'd1);
    chk("ovr_data",  64'(out_data), 64'h1);
    chk("ovr_acc",   64'(m_acc - b_acc), 64'd0);
    out_ready = 1'b1;
    @(negedge clk); chk("ovr_hs_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    @(negedge clk); chk("ovr_drop_valid", 64'(out_valid), 64'd0);
    tick(1);
    chk("ovr_acc2",  64'(m_acc - b_acc), 64'd1);
    chk("ovr_accd",  64'(acc_mem[b_acc % 256]), 64'h1);

    // Async reset in the middle of a frame
    snap();
    sframe_in = 1'b1; sclk_in = 1'b0; tick(2);
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    tick(4);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy",  64'(busy), 64'd0);
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_data",  64'(out_data), 64'd0);
    sframe_in = 1'b0; sclk_in = 1'b0; tick(3);
    rst_n = 1'b1; tick(2);
    send_frame(42'h155_5555_5555, 42, 0, 0, 0);
    check_frame("post_rst", 42'h155_5555_5555, 42, 1, 42'h155_5555_5555, 0);

`ifdef SREG_RX_TIMEOUT_EN
    // Stall mid-frame
    snap();
    sframe_in = 1'b1; sclk_in = 1'b0; tick(2);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    sclk_in = 1'b0; tick(70);
    chk("to_count", 64'(m_to - b_to), 64'd1);
    chk("to_busy",  64'(busy), 64'd0);
    sframe_in = 1'b0; tick(10);
    chk("to_short", 64'(m_short - b_short), 64'd0);
    chk("to_words", 64'(m_acc - b_acc), 64'd0);
`endif

    // Randomised frames against the protocol model
    for (int k = 0; k < 24; k++) begin
      r = {32'($urandom), 32'($urandom)};
      w = r[W-1:0];
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin nb = int'($urandom_range(1, 41)); ex = 0; end
      else           begin nb = W; ex = int'($urandom_range(0, 3)); end
      snap();
      send_frame(w, nb, ex, 0, 0);
      check_frame($sformatf("rnd%0d", k), w, nb, (nb >= W) ? 1 : 0, w, (nb < W) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
